debug_frame_tx: RTL

//  Serialises a wide, parametrised debug snapshot (pipeline regs, register file, memory words) into

---
 rtl/debug_frame_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/debug_frame_tx.sv
// Byte serialiser for debug snapshots into the UART TX FIFO,
// with optional header byte and trailing XOR checksum.
module debug_frame_tx #(
   parameter int unsigned DATA_BYTES    = 220,
   parameter bit          SEND_HEADER   = 1'b1,
   parameter logic [7:0]  HEADER_BYTE   = 8'hA5,
   parameter bit          SEND_CHECKSUM = 1'b1,
   parameter bit          MSB_FIRST     = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tx_full,
   input  logic                    send,
   input  logic                    abort,
   input  logic [8*DATA_BYTES-1:0] send_data,
   output logic                    wr_uart,
   output logic [7:0]              w_data,
   output logic                    busy,
   output logic                    data_sent
);

   localparam int unsigned    IW   = $clog2(DATA_BYTES) + 1;
   localparam logic [IW-1:0]  LAST = IW'(DATA_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      DATA,
      CHECK,
      DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [8*DATA_BYTES-1:0] shadow_q, shadow_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [7:0]              csum_q, csum_d;
   logic                    busy_q, busy_d;
   logic [7:0]              pl_byte;
   logic                    can_wr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         idx_q    <= '0;
         csum_q   <= 8'h00;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         csum_q   <= csum_d;
         busy_q   <= busy_d;
      end
   end

   // Payload byte currently addressed by idx, in wire order.
   always_comb begin
      pl_byte = 8'h00;
      for (int i = 0; i < int'(DATA_BYTES); i++) begin
         if (idx_q == IW'(i)) begin
            if (MSB_FIRST)
               pl_byte = shadow_q[8*(int'(DATA_BYTES)-1-i) +: 8];
            else
               pl_byte = shadow_q[8*i +: 8];
         end
      end
   end

   assign can_wr = !tx_full && !abort;
   assign busy   = busy_q;

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      busy_d    = busy_q;
      wr_uart   = 1'b0;
      w_data    = 8'h00;
      data_sent = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (send) begin
               shadow_d = send_data;
               csum_d   = 8'h00;
               idx_d    = '0;
               busy_d   = 1'b1;
               state_d  = SEND_HEADER ? HEADER : DATA;
            end
         end
         HEADER: begin
            wr_uart = can_wr;
            if (can_wr) begin
               w_data  = HEADER_BYTE;
               state_d = DATA;
            end
         end
         DATA: begin
            wr_uart = can_wr;
            if (can_wr) begin
               w_data = pl_byte;
               csum_d = csum_q ^ pl_byte;
               idx_d  = idx_q + IW'(1);
               if (idx_q == LAST)
                  state_d = SEND_CHECKSUM ? CHECK : DONE;
            end
         end
         CHECK: begin
            wr_uart = can_wr;
            if (can_wr) begin
               w_data  = csum_q;
               state_d = DONE;
            end
         end
         DONE: begin
            data_sent = !abort;
            state_d   = IDLE;
            busy_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides every non-idle transition, including DONE.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end
   end

endmodule
